fft_bitrev_pingpong: RTL and testbench

- Parametrised streaming reorder buffer placed at the output of the FFT datapath.
- Accepts complex samples in natural order, one frame of N = 2**LOG2_N points at a time.
- Emits each frame in bit-reversed order, so a DIF FFT core's results reach downstream logic in natural frequency order.
- Two ping-pong banks let frame k+1 fill while frame k drains; valid/ready handshakes on both sides replace the free-running, handshake-less stream of the fixed 16-point unit.

---
 rtl/fft_bitrev_pingpong_pkg.sv | 27 ++
 rtl/fft_bitrev_pingpong_if.sv | 37 +++
 rtl/fft_bitrev_pingpong_bank.sv | 24 ++
 rtl/fft_bitrev_pingpong.sv | 124 ++++++++++++
 tb/tb_fft_bitrev_pingpong.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_bitrev_pingpong_pkg.sv
// fft_pkg: shared types and helpers for the ping-pong bit-reversal reorder buffer.
package fft_pkg;

    // Largest supported frame is 2**MAX_LOG2_N points.
    localparam int MAX_LOG2_N = 10;

    typedef logic [MAX_LOG2_N-1:0] max_idx_t;

    // Read-side FSM: wait for a full bank, then stream it out.
    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_t;

    // Frame length N for a given log2 size.
    function automatic int frame_len(input int log2_n);
        return 1 << log2_n;
    endfunction

    // Reverse the low log2_n bits of x; bits above log2_n come back as zero.
    function automatic max_idx_t bitrev(input max_idx_t x, input int log2_n);
        max_idx_t rev;
        rev = {<<{x}};
        return rev >> (MAX_LOG2_N - log2_n);
    endfunction

endpackage

// File: rtl/fft_bitrev_pingpong_if.sv
// fft_bitrev_pingpong_if: input and output valid/ready streams of the reorder buffer.
// Optional macro FFT_OUT_LAST_EN adds the out_last frame marker.
interface fft_bitrev_pingpong_if #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_r;
    logic [DATA_W-1:0] in_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_r;
    logic [DATA_W-1:0] out_i;
    logic [LOG2_N-1:0] out_idx;
`ifdef FFT_OUT_LAST_EN
    logic              out_last;
`endif

    // Upstream producer and downstream consumer side.
    modport master (
`ifdef FFT_OUT_LAST_EN
        input  out_last,
`endif
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx
    );

    // The reorder buffer itself.
    modport slave (
`ifdef FFT_OUT_LAST_EN
        output out_last,
`endif
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx
    );
endinterface

// File: rtl/fft_bitrev_pingpong_bank.sv
// fft_pp_bank: one N-entry sample bank, synchronous write, combinational read.
module fft_pp_bank #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one sample per accepted input.
    // NOTE: no reset on the array -- every entry is written before its bank is marked full and read.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fft_bitrev_pingpong.sv
// fft_bitrev_pingpong: streaming natural-order to bit-reversed-order reorder buffer
// with two ping-pong banks and valid/ready handshakes on both sides.
// Optional macro FFT_OUT_LAST_EN adds out_last, registered with the output stage.
module fft_bitrev_pingpong
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_bitrev_pingpong_if.slave  bus
);
    localparam int N = frame_len(LOG2_N);
    localparam int W = 2 * DATA_W;

    typedef logic [LOG2_N-1:0] idx_t;
    localparam idx_t LAST = idx_t'(N - 1);

    idx_t      wr_cnt, rd_cnt, rd_addr;
    logic      wr_sel, rd_sel;
    logic [1:0] full;
    logic      wr_en, wr_last, load, rd_last;
    logic [W-1:0] rd_data [2];
    rd_state_t state, state_nx;

    // A bank being filled is never full, so the write side only waits on the bank it targets.
    assign bus.in_ready = ~full[wr_sel];
    assign wr_en        = bus.in_valid & bus.in_ready;
    assign wr_last      = wr_en && (wr_cnt == LAST);
    assign rd_addr      = idx_t'(bitrev(max_idx_t'(rd_cnt), LOG2_N));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_pp_bank #(.WIDTH(W), .AW(LOG2_N)) u_bank (
            .clk     (clk),
            .we      (wr_en && (wr_sel == 1'(b))),
            .wr_addr (wr_cnt),
            .wr_data ({bus.in_r, bus.in_i}),
            .rd_addr (rd_addr),
            .rd_data (rd_data[b])
        );
    end

    // Write side: fill the selected bank in natural order, switch banks after the last point.
    // NOTE: sequential state uses <= so every register in the design samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
        end else if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_last) wr_sel <= ~wr_sel;
        end
    end

    // Full flags: set by the write side, cleared by the read side; the two never hit the same bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (wr_last) full[wr_sel] <= 1'b1;
            if (rd_last) full[rd_sel] <= 1'b0;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= R_IDLE;
        else     state <= state_nx;
    end

    // Read FSM next state: stream while a full bank is available, chain frames without a bubble.
    // NOTE: state_nx gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            R_IDLE:   if (full[rd_sel]) state_nx = R_STREAM;
            R_STREAM: if (rd_last && !full[~rd_sel]) state_nx = R_IDLE;
            default:  state_nx = R_IDLE;
        endcase
    end

    // Read FSM outputs: load the output register whenever it is empty or being consumed.
    always_comb begin
        load    = (state == R_STREAM) && (!bus.out_valid || bus.out_ready);
        rd_last = load && (rd_cnt == LAST);
    end

    // Read counter and bank select advance on every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            rd_sel <= 1'b0;
        end else if (load) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_last) rd_sel <= ~rd_sel;
        end
    end

    // Output register: holds its sample while out_valid & ~out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_r     <= '0;
            bus.out_i     <= '0;
            bus.out_idx   <= '0;
`ifdef FFT_OUT_LAST_EN
            bus.out_last  <= 1'b0;
`endif
        end else if (load) begin
            bus.out_valid           <= 1'b1;
            {bus.out_r, bus.out_i}  <= rd_data[rd_sel];
            bus.out_idx             <= rd_cnt;
`ifdef FFT_OUT_LAST_EN
            bus.out_last            <= (rd_cnt == LAST);
`endif
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
`ifdef FFT_OUT_LAST_EN
            bus.out_last  <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_fft_bitrev_pingpong.sv
// tb_fft_bitrev_pingpong: self-checking bench for the ping-pong bit-reversal buffer.
// Honours FFT_OUT_LAST_EN when defined for the build.
module tb_fft_bitrev_pingpong;
    localparam int DW   = 16;
    localparam int LN   = 4;
    localparam int N    = 16;
    localparam int DW_B = 12;
    localparam int LN_B = 3;

    logic clk;
    logic rst;

    fft_bitrev_pingpong_if #(.DATA_W(DW),   .LOG2_N(LN))   a_bus ();
    fft_bitrev_pingpong_if #(.DATA_W(DW_B), .LOG2_N(LN_B)) b_bus ();

    fft_bitrev_pingpong #(.DATA_W(DW), .LOG2_N(LN)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_bus.slave)
    );

    fft_bitrev_pingpong #(.DATA_W(DW_B), .LOG2_N(LN_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        int            idx;
    } out_t;

    typedef struct {
        int in_r;
        int exp_r;
        int exp_idx;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc_step = -1;
    int first_valid_step = -1;

    out_t            exp_q[$];
    logic [2*DW-1:0] frame_q[$];
    int              got_r[$];
    int              got_idx[$];
    int              got_cyc[$];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference bit reversal by plain arithmetic.
    function automatic int rev_idx(input int k, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = (r << 1) | ((k >> b) & 1);
        return r;
    endfunction

    // Reference model: collect accepted samples; each complete frame yields N outputs in bit-reversed order.
    task automatic model_push(input logic [DW-1:0] r, input logic [DW-1:0] i);
        out_t e;
        frame_q.push_back({r, i});
        if (frame_q.size() == N) begin
            for (int k = 0; k < N; k++) begin
                e.r   = frame_q[rev_idx(k, LN)][2*DW-1:DW];
                e.i   = frame_q[rev_idx(k, LN)][DW-1:0];
                e.idx = k;
                exp_q.push_back(e);
            end
            frame_q.delete();
        end
    endtask

    task automatic check_out();
        out_t e;
        got_r.push_back(int'($signed(a_bus.out_r)));
        got_idx.push_back(int'(a_bus.out_idx));
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
            check("out_unexpected", a_bus.out_valid, 0);
            return;
        end
        e = exp_q.pop_front();
        check("out_r", $signed(a_bus.out_r), $signed(e.r));
        check("out_i", $signed(a_bus.out_i), $signed(e.i));
        check("out_idx", a_bus.out_idx, e.idx);
`ifdef FFT_OUT_LAST_EN
        check("out_last", a_bus.out_last, (e.idx == N - 1));
`endif
    endtask

    // One clock of DUT A: drive inputs, book transfers that happen at the coming edge, advance.
    task automatic cycle_a(input logic iv, input int r, input int i, input logic ordy, output logic acc);
        a_bus.in_valid  = iv;
        a_bus.in_r      = DW'(r);
        a_bus.in_i      = DW'(i);
        a_bus.out_ready = ordy;
        acc = iv && a_bus.in_ready;
        if (a_bus.out_valid && first_valid_step < 0) first_valid_step = cyc;
        if (acc) begin
            model_push(DW'(r), DW'(i));
            last_acc_step = cyc;
        end
        if (a_bus.out_valid && ordy) check_out();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed_a(input int count, input int base, input logic ordy, input int bound, output int n);
        logic acc;
        int k = 0;
        n = 0;
        while (n < count && k < bound) begin
            cycle_a(1'b1, base + n, 0, ordy, acc);
            if (acc) n++;
            k++;
        end
    endtask

    task automatic drain_a(input int bound, input string name);
        logic acc;
        int k = 0;
        while ((exp_q.size() != 0 || a_bus.out_valid) && k < bound) begin
            cycle_a(1'b0, 0, 0, 1'b1, acc);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic clear_log();
        got_r.delete();
        got_idx.delete();
        got_cyc.delete();
    endtask

    initial begin
        vec_t vec[N];
        int   exp1[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int   exp2[4] = '{16, 24, 20, 28};
        vec_t vb[8];
        int   expb[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        logic acc;
        int   n, nb, ob;
        int   rr, ii;
        logic iv, ordy;

        for (int k = 0; k < N; k++) vec[k] = '{k, exp1[k], k};
        for (int k = 0; k < 8; k++) vb[k] = '{k, expb[k], k};

        rst = 1'b1;
        a_bus.in_valid = 1'b0; a_bus.in_r = '0; a_bus.in_i = '0; a_bus.out_ready = 1'b0;
        b_bus.in_valid = 1'b0; b_bus.in_r = '0; b_bus.in_i = '0; b_bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", a_bus.out_valid, 0);
        check("rst_in_ready", a_bus.in_ready, 1);
        check("rst_out_r", a_bus.out_r, 0);
        check("rst_out_i", a_bus.out_i, 0);
        check("rst_out_idx", a_bus.out_idx, 0);

        // Single frame 0..15, table-driven
        clear_log();
        for (int k = 0; k < N; k++) begin
            cycle_a(1'b1, vec[k].in_r, 0, 1'b1, acc);
            check("t1_accept", acc, 1);
        end
        drain_a(60, "t1_drain");
        check("t1_latency", first_valid_step - (last_acc_step + 1), 2);
        check("t1_count", got_r.size(), N);
        if (got_r.size() >= N) begin
            for (int k = 0; k < N; k++) begin
                check("t1_out_r", got_r[k], vec[k].exp_r);
                check("t1_out_idx", got_idx[k], vec[k].exp_idx);
            end
        end

        // Three back-to-back frames 0..47
        clear_log();
        feed_a(48, 0, 1'b1, 200, n);
        check("t2_accepted", n, 48);
        drain_a(100, "t2_drain");
        check("t2_count", got_r.size(), 48);
        if (got_r.size() == 48) begin
            for (int k = 0; k < 4; k++) check("t2_frame1_start", got_r[16 + k], exp2[k]);
            check("t2_no_bubble", got_cyc[16] - got_cyc[15], 1);
        end

        // Output stalled: two frames fit, then input stalls
        clear_log();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            cycle_a(1'b1, n, 0, 1'b0, acc);
            if (acc) n++;
        end
        check("t3_accepted", n, 32);
        check("t3_in_ready", a_bus.in_ready, 0);
        check("t3_out_valid", a_bus.out_valid, 1);
        check("t3_out_r", a_bus.out_r, 0);
        for (int k = 0; k < 5; k++) cycle_a(1'b0, 0, 0, 1'b0, acc);
        check("t3_hold_valid", a_bus.out_valid, 1);
        check("t3_hold_r", a_bus.out_r, 0);
        check("t3_hold_idx", a_bus.out_idx, 0);
        drain_a(200, "t3_drain");
        check("t3_count", got_r.size(), 32);
        if (got_r.size() >= 2) check("t3_second", got_r[1], 8);

        // Random gaps on both sides, signed data
        clear_log();
        n = 0;
        for (int k = 0; k < 2000 && n < 64; k++) begin
            iv   = (n < 64) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 1) == 1);
            rr   = int'($urandom_range(0, 15)) - 8;
            ii   = 100 + int'($urandom_range(0, 15));
            cycle_a(iv, rr, ii, ordy, acc);
            if (acc) n++;
        end
        check("t4_accepted", n, 64);
        drain_a(200, "t4_drain");
        check("t4_count", got_r.size(), 64);

        // Reset mid-frame with a full bank and a valid output pending
        clear_log();
        feed_a(25, 0, 1'b0, 100, n);
        check("t5_prefill", n, 25);
        rst = 1'b1;
        #1;
        check("t5_rst_out_valid", a_bus.out_valid, 0);
        check("t5_rst_in_ready", a_bus.in_ready, 1);
        check("t5_rst_out_r", a_bus.out_r, 0);
        check("t5_rst_out_idx", a_bus.out_idx, 0);
        exp_q.delete();
        frame_q.delete();
        #2;
        rst = 1'b0;
        clear_log();
        feed_a(16, 0, 1'b1, 100, n);
        check("t5_accepted", n, 16);
        drain_a(60, "t5_drain");
        check("t5_count", got_r.size(), 16);
        if (got_r.size() >= 2) check("t5_second", got_r[1], 8);

        // Eight-point instance, table-driven
        nb = 0;
        ob = 0;
        for (int k = 0; k < 60 && ob < 8; k++) begin
            b_bus.in_valid  = (nb < 8);
            b_bus.in_r      = DW_B'((nb < 8) ? vb[nb].in_r : 0);
            b_bus.in_i      = DW_B'(-1 - nb);
            b_bus.out_ready = 1'b1;
            if (b_bus.out_valid) begin
                check("b_out_r", $signed(b_bus.out_r), vb[ob].exp_r);
                check("b_out_i", $signed(b_bus.out_i), -1 - vb[ob].exp_r);
                check("b_out_idx", b_bus.out_idx, vb[ob].exp_idx);
`ifdef FFT_OUT_LAST_EN
                check("b_out_last", b_bus.out_last, (ob == 7));
`endif
                ob++;
            end
            if (b_bus.in_valid && b_bus.in_ready) nb++;
            @(posedge clk);
            #1;
        end
        check("b_count", ob, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
